// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the data-memory load/store unit:
//                access-mode encodings, FSM state type, byte-enable base
//                masks and the access legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // mem_acc_mode encodings as produced by instruction decode
    localparam logic [2:0] MEM_B    = 3'b000;
    localparam logic [2:0] MEM_H    = 3'b001;
    localparam logic [2:0] MEM_W    = 3'b010;
    localparam logic [2:0] MEM_BU   = 3'b011;
    localparam logic [2:0] MEM_HU   = 3'b100;
    localparam logic [2:0] MEM_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Byte-enable masks for lane 0; shifted up by the byte offset for stores
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // 1 when the requested access may be issued on the bus
    function automatic logic access_legal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] mode,
        input logic [1:0] off
    );
        logic ok;
        ok = !(rd && wr);
        case (mode)
            MEM_B:   ;
            MEM_BU:  if (wr) ok = 1'b0;
            MEM_H:   if (off[0]) ok = 1'b0;
            MEM_HU:  if (wr || off[0]) ok = 1'b0;
            MEM_W:   if (off != 2'b00) ok = 1'b0;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_data_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_data_align
//  Description : Combinational lane steering for the load/store unit.
//                Store side: replicates store data across lanes and builds
//                byte enables. Load side: selects the addressed byte/half of
//                the returned word and sign- or zero-extends it.
//  Ports       : i_mode      access size/sign mode
//                i_off       byte offset within the word
//                i_we        1 = store (enables lane-specific byte enables)
//                i_st_data   store data (rs2)
//                i_ld_word   word returned by memory
//                o_st_wdata  lane-replicated store data
//                o_be        byte enables
//                o_ld_data   extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_data_align (
    input  logic [2:0]  i_mode,
    input  logic [1:0]  i_off,
    input  logic        i_we,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_ld_data
);
    import lsu_pkg::*;

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Store path
    always_comb begin
        o_st_wdata = i_st_data;
        o_be       = BE_WORD;
        case (i_mode)
            MEM_B, MEM_BU: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_be       = BE_BYTE << i_off;
            end
            MEM_H, MEM_HU: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_be       = BE_HALF << i_off;
            end
            default: ;
        endcase
        // Loads always fetch the whole word
        if (!i_we) begin
            o_be = BE_WORD;
        end
    end

    // Load path
    always_comb begin
        case (i_off)
            2'd0:    w_ld_byte = i_ld_word[7:0];
            2'd1:    w_ld_byte = i_ld_word[15:8];
            2'd2:    w_ld_byte = i_ld_word[23:16];
            default: w_ld_byte = i_ld_word[31:24];
        endcase
        w_ld_half = i_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

        case (i_mode)
            MEM_B:   o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            MEM_BU:  o_ld_data = {24'd0, w_ld_byte};
            MEM_H:   o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            MEM_HU:  o_ld_data = {16'd0, w_ld_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_lsu
//  Description : Load/store responder between decode/ALU and a valid/ready
//                word-addressed memory bus. Stalls the core until the access
//                retires and pulses err on illegal, misaligned or timed-out
//                accesses.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                rd_en, wr_en             load / store request
//                mem_acc_mode             access size and sign mode
//                addr, wdata              byte address, store data
//                rdata                    extended load result (valid in DONE)
//                stall, err               pipeline hold, error pulse
//                req_valid/ready/we/addr/wdata/be   bus request channel
//                resp_valid, resp_rdata   bus read response
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_lsu #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int AW             = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [2:0]    mem_acc_mode,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          err,
    output logic          req_valid,
    input  logic          req_ready,
    output logic          req_we,
    output logic [AW-1:0] req_addr,
    output logic [31:0]   req_wdata,
    output logic [3:0]    req_be,
    input  logic          resp_valid,
    input  logic [31:0]   resp_rdata
);
    import lsu_pkg::*;

    localparam int              c_cnt_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    lsu_state_t           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_req_valid;
    logic                 r_req_we;
    logic [AW-1:0]        r_req_addr;
    logic [31:0]          r_req_wdata;
    logic [3:0]           r_req_be;
    logic [2:0]           r_mode;
    logic [1:0]           r_off;
    logic [31:0]          r_rdata;
    logic                 r_err;

    logic                 w_access;
    logic                 w_legal;
    logic                 w_idle;
    logic [2:0]           w_sel_mode;
    logic [1:0]           w_sel_off;
    logic [31:0]          w_st_wdata;
    logic [3:0]           w_st_be;
    logic [31:0]          w_ld_data;
    logic                 w_tmo;

    assign w_access = rd_en | wr_en;
    assign w_legal  = access_legal(rd_en, wr_en, mem_acc_mode, addr[1:0]);
    assign w_idle   = (r_state == ST_IDLE);
    assign w_tmo    = (r_cnt == c_tmo_last);

    // The aligner sees the live request while it is being registered in
    // IDLE, and the registered copy afterwards for extracting the load.
    assign w_sel_mode = w_idle ? mem_acc_mode : r_mode;
    assign w_sel_off  = w_idle ? addr[1:0]    : r_off;

    mem_data_align u_align (
        .i_mode     (w_sel_mode),
        .i_off      (w_sel_off),
        .i_we       (wr_en),
        .i_st_data  (wdata),
        .i_ld_word  (resp_rdata),
        .o_st_wdata (w_st_wdata),
        .o_be       (w_st_be),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= '0;
            r_mode      <= MEM_NONE;
            r_off       <= 2'b00;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_access) begin
                        if (w_legal) begin
                            r_req_valid <= 1'b1;
                            r_req_we    <= wr_en;
                            r_req_addr  <= {addr[AW-1:2], 2'b00};
                            r_req_wdata <= w_st_wdata;
                            r_req_be    <= w_st_be;
                            r_mode      <= mem_acc_mode;
                            r_off       <= addr[1:0];
                            r_state     <= ST_REQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Completion in the final cycle wins over the timeout
                    if (req_ready && r_req_we) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (req_ready && resp_valid) begin
                        r_req_valid <= 1'b0;
                        r_rdata     <= w_ld_data;
                        r_state     <= ST_DONE;
                    end else if (w_tmo) begin
                        r_req_valid <= 1'b0;
                        r_rdata     <= '0;
                        r_err       <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (resp_valid) begin
                        r_rdata <= w_ld_data;
                        r_state <= ST_DONE;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Any access presented in IDLE holds the core, including an illegal one:
    // the core must not advance until err is reported in DONE, otherwise the
    // following instruction would arrive during DONE and be dropped.
    assign stall = ~rst & ((w_idle & w_access) |
                           (r_state == ST_REQ) |
                           (r_state == ST_WAIT));

    assign req_valid = r_req_valid & ~rst;
    assign req_we    = r_req_we;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_be    = r_req_be;
    assign rdata     = r_rdata;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_lsu
//  Description : Directed self-checking bench for data_mem_lsu with a small
//                bus responder (configurable ready and response delays).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_lsu;

    localparam int AW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    mem_acc_mode = 3'b111;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          stall;
    logic          err;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          resp_valid = 1'b0;
    logic [31:0]   resp_rdata = '0;

    always #5 clk = ~clk;

    data_mem_lsu #(.TIMEOUT_CYCLES(TMO), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .mem_acc_mode (mem_acc_mode),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .err          (err),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata)
    );

    int          n_checks = 0;
    int          n_errors = 0;

    int          stall_cycles;
    int          valid_cycles;
    int          err_cycles;
    logic        done_seen;
    logic        done_err;
    logic [31:0] done_rdata;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic        post_err;
    logic        post_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one access, acts as the memory, and records what happened
    // until the first non-stalled cycle (DONE). ready_delay: req_valid cycles
    // before req_ready rises (<0 never). resp_delay: cycles after handshake
    // before resp_valid (0 = same cycle, <0 never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] mode,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ready_delay, input int resp_delay,
                              input logic [31:0] word);
        int hs_k;
        hs_k = -1;
        stall_cycles = 0; valid_cycles = 0; err_cycles = 0;
        done_seen = 1'b0; done_err = 1'b0; done_rdata = '0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        @(negedge clk);
        rd_en = rd; wr_en = wr; mem_acc_mode = mode; addr = a; wdata = wd;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = word;
        for (int k = 0; k < 40 && !done_seen; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            req_ready  = req_valid && (ready_delay >= 0) && (valid_cycles >= ready_delay);
            resp_valid = rd && (resp_delay >= 0) &&
                         ((req_valid && req_ready && resp_delay == 0) ||
                          (hs_k >= 0 && k == hs_k + resp_delay));
            #1;
            if (stall) stall_cycles++;
            else begin
                done_seen  = 1'b1;
                done_err   = err;
                done_rdata = rdata;
            end
            if (err) err_cycles++;
            if (req_valid) begin
                valid_cycles++;
                cap_addr  = req_addr;
                cap_wdata = req_wdata;
                cap_be    = req_be;
                cap_we    = req_we;
                if (req_ready) hs_k = k;
            end
        end
        chk("done_within_bound", done_seen, 1'b1);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'b111;
        req_ready = 1'b0; resp_valid = 1'b0;
        #1;
        post_err   = err;
        post_valid = req_valid;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        rd_en = 1'b1; mem_acc_mode = 3'b010;
        #1;
        chk("stall_forced_low_in_reset", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0; mem_acc_mode = 3'b111;
        #1;
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_we",    req_we,    1'b0);
        chk("rst_req_be",    req_be,    4'h0);
        chk("rst_req_addr",  req_addr,  32'h0);
        chk("rst_req_wdata", req_wdata, 32'h0);
        chk("rst_rdata",     rdata,     32'h0);
        chk("rst_err",       err,       1'b0);
        chk("rst_stall",     stall,     1'b0);

        // ---------------- load byte signed ----------------
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_1234);
        chk("lb_req_addr", cap_addr,     32'h100);
        chk("lb_req_be",   cap_be,       4'hF);
        chk("lb_req_we",   cap_we,       1'b0);
        chk("lb_stall",    stall_cycles, 3);
        chk("lb_valid",    valid_cycles, 1);
        chk("lb_rdata",    done_rdata,   32'hFFFF_FF80);
        chk("lb_err",      err_cycles,   0);

        // ---------------- load half unsigned ----------------
        run_access(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 0, 1, 32'hBEEF_0001);
        chk("lhu_req_addr", cap_addr,   32'h200);
        chk("lhu_rdata",    done_rdata, 32'h0000_BEEF);

        // ---------------- load half signed, response with handshake ----------------
        run_access(1'b1, 1'b0, 3'b001, 32'h206, 32'h0, 0, 0, 32'h8001_7FFF);
        chk("lh_stall", stall_cycles, 2);
        chk("lh_rdata", done_rdata,   32'hFFFF_8001);

        // ---------------- load byte unsigned ----------------
        run_access(1'b1, 1'b0, 3'b011, 32'h601, 32'h0, 0, 1, 32'h1122_8344);
        chk("lbu_rdata", done_rdata, 32'h0000_0083);

        // ---------------- load word, slow response ----------------
        run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, 3, 32'hCAFE_F00D);
        chk("lw_stall", stall_cycles, 5);
        chk("lw_rdata", done_rdata,   32'hCAFE_F00D);
        chk("lw_err",   done_err,     1'b0);

        // ---------------- store word, minimum latency ----------------
        run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, -1, 32'h0);
        chk("sw_stall", stall_cycles, 2);
        chk("sw_we",    cap_we,       1'b1);
        chk("sw_be",    cap_be,       4'hF);
        chk("sw_wdata", cap_wdata,    32'hDEAD_BEEF);
        chk("sw_rdata_kept", done_rdata, 32'hCAFE_F00D);

        // ---------------- store byte, ready delayed ----------------
        run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_00AB, 4, -1, 32'h0);
        chk("sb_req_addr", cap_addr,     32'h300);
        chk("sb_be",       cap_be,       4'b0010);
        chk("sb_wdata",    cap_wdata,    32'hABAB_ABAB);
        chk("sb_valid",    valid_cycles, 5);
        chk("sb_stall",    stall_cycles, 6);
        chk("sb_err",      done_err,     1'b0);

        // ---------------- store half upper lane ----------------
        run_access(1'b0, 1'b1, 3'b001, 32'h702, 32'h1234_5678, 0, -1, 32'h0);
        chk("sh_be",    cap_be,    4'b1100);
        chk("sh_wdata", cap_wdata, 32'h5678_5678);

        // ---------------- misaligned word load ----------------
        run_access(1'b1, 1'b0, 3'b010, 32'h402, 32'h0, 0, 1, 32'h5555_5555);
        chk("mis_valid",     valid_cycles, 0);
        chk("mis_err_done",  done_err,     1'b1);
        chk("mis_err_count", err_cycles,   1);
        chk("mis_err_after", post_err,     1'b0);
        chk("mis_stall",     stall_cycles, 1);
        chk("mis_rdata",     done_rdata,   32'hCAFE_F00D);

        // ---------------- illegal: unsigned-mode store ----------------
        run_access(1'b0, 1'b1, 3'b011, 32'h800, 32'hFF, 0, -1, 32'h0);
        chk("ill_bu_valid", valid_cycles, 0);
        chk("ill_bu_err",   done_err,     1'b1);

        // ---------------- illegal: read and write together ----------------
        run_access(1'b1, 1'b1, 3'b010, 32'h800, 32'h0, 0, 1, 32'h0);
        chk("ill_rw_valid", valid_cycles, 0);
        chk("ill_rw_err",   done_err,     1'b1);

        // ---------------- timeout ----------------
        run_access(1'b1, 1'b0, 3'b010, 32'h900, 32'h0, -1, -1, 32'h0);
        chk("tmo_valid",     valid_cycles, TMO);
        chk("tmo_stall",     stall_cycles, TMO + 1);
        chk("tmo_err",       done_err,     1'b1);
        chk("tmo_err_count", err_cycles,   1);
        chk("tmo_rdata",     done_rdata,   32'h0);
        chk("tmo_valid_after", post_valid, 1'b0);

        // ---------------- reset mid-access ----------------
        // Make rdata non-zero first so the reset clearing it is visible
        run_access(1'b1, 1'b0, 3'b010, 32'hA00, 32'h0, 0, 1, 32'h1357_9BDF);
        chk("pre_rst_rdata", done_rdata, 32'h1357_9BDF);
        @(negedge clk);
        rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'hA04; req_ready = 1'b1;
        #1;
        chk("rma_idle_stall", stall, 1'b1);
        @(negedge clk);
        #1;
        chk("rma_req_valid", req_valid, 1'b1);
        @(negedge clk);
        req_ready = 1'b0; rst = 1'b1;
        #1;
        chk("rma_wait_stall_in_rst", stall,     1'b0);
        chk("rma_valid_in_rst",      req_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0; mem_acc_mode = 3'b111;
        resp_valid = 1'b1; resp_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rma_stall", stall,     1'b0);
        chk("rma_valid", req_valid, 1'b0);
        chk("rma_rdata", rdata,     32'h0);
        @(negedge clk);
        resp_valid = 1'b0;
        #1;
        chk("rma_rdata_late", rdata, 32'h0);
        chk("rma_err_late",   err,   1'b0);
        chk("rma_stall_late", stall, 1'b0);

        // FSM back in IDLE: a normal access completes with minimum latency
        run_access(1'b1, 1'b0, 3'b000, 32'hB02, 32'h0, 0, 1, 32'h0042_0000);
        chk("post_rst_stall", stall_cycles, 3);
        chk("post_rst_rdata", done_rdata,   32'h0000_0042);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
